// File: rtl/fuel_meter_pkg.sv
// Shared types and default constants for the ultrasonic fuel level meter.
// The sum width is derived from the pings-per-burst count.
package fuel_meter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPing,
    StConvert,
    StAccum,
    StGap,
    StDone,
    StAbort
  } burst_state_e;

  typedef enum logic [1:0] {
    PtIdle,
    PtTrig,
    PtWaitRise,
    PtMeasure
  } ping_state_e;

  localparam int unsigned ScaleQDefault  = 5785;
  localparam int unsigned ScaleShDefault = 24;
  localparam int unsigned TankHCmDefault = 100;
  localparam int unsigned AreaCm2Default = 400;

  function automatic int unsigned sum_width(input int unsigned cm_w, input int unsigned avg_log2);
    return cm_w + $clog2(2 ** avg_log2);
  endfunction

endpackage

// File: rtl/echo_pulse_timer.sv
// One ping: trigger pulse, synchronised echo edge detection, echo width count and timeout.
// raw is valid in the cycle done strobes.
module echo_pulse_timer
  import fuel_meter_pkg::*;
#(
  parameter int unsigned RAW_W       = 21,
  parameter int unsigned TRIG_CYC    = 500,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ping_start,
  input  logic             echo,
  output logic             trig,
  output logic [RAW_W-1:0] raw,
  output logic             done,
  output logic             timeout
);

  localparam logic [RAW_W-1:0] TrigLast    = RAW_W'(TRIG_CYC - 1);
  localparam logic [RAW_W-1:0] TimeoutLast = RAW_W'(TIMEOUT_CYC - 1);

  ping_state_e      state_q, state_d;
  logic [RAW_W-1:0] cnt_q, cnt_d;
  logic             trig_q, trig_d;
  logic             echo_meta_q, echo_s_q, echo_prev_q;
  logic             rise;

  // echo_prev_q tracks every cycle, so a level already high on entry is not a rise
  assign rise = echo_s_q & ~echo_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      PtIdle: begin
        if (ping_start) begin
          state_d = PtTrig;
          cnt_d   = '0;
        end
      end
      PtTrig: begin
        if (cnt_q == TrigLast) begin
          state_d = PtWaitRise;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PtWaitRise: begin
        if (rise) begin
          state_d = PtMeasure;
          cnt_d   = RAW_W'(1);
        end else if (cnt_q == TimeoutLast) begin
          timeout = 1'b1;
          state_d = PtIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PtMeasure: begin
        if (!echo_s_q) begin
          done    = 1'b1;
          state_d = PtIdle;
        end else if (cnt_q == TimeoutLast) begin
          timeout = 1'b1;
          state_d = PtIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = PtIdle;
    endcase
    trig_d = (state_d == PtTrig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PtIdle;
      cnt_q       <= '0;
      trig_q      <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trig_q      <= trig_d;
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
    end
  end

  assign trig = trig_q;
  assign raw  = cnt_q;

endmodule

// File: rtl/echo_level_meter.sv
// Burst sequencer: times 2**AVG_LOG2 echoes, converts each to cm, averages them and
// derives the fuel volume from tank geometry.
module echo_level_meter
  import fuel_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned RAW_W       = 21,
  parameter int unsigned CM_W        = 16,
  parameter int unsigned ML_W        = 24,
  parameter int unsigned TRIG_CYC    = CLK_HZ / 100_000,
  parameter int unsigned TIMEOUT_CYC = CLK_HZ / 25,
  parameter int unsigned GAP_CYC     = (CLK_HZ / 50) * 3,
  parameter int unsigned SCALE_Q     = ScaleQDefault,
  parameter int unsigned SCALE_SH    = ScaleShDefault,
  parameter int unsigned TANK_H_CM   = TankHCmDefault,
  parameter int unsigned AREA_CM2    = AreaCm2Default,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            echo,
  output logic            trig,
  output logic            busy,
  output logic [CM_W-1:0] dist_cm,
  output logic [ML_W-1:0] vol_ml,
  output logic            valid,
  output logic            err
);

  localparam int unsigned Pings = 2 ** AVG_LOG2;
  localparam int unsigned SumW  = sum_width(CM_W, AVG_LOG2);
  localparam int unsigned ProdW = RAW_W + 16;
  localparam int unsigned GapW  = $clog2(GAP_CYC + 1);
  localparam int unsigned PcntW = AVG_LOG2 + 1;
  localparam int unsigned VolW  = CM_W + 32;
  localparam logic [CM_W-1:0] CmMax = {CM_W{1'b1}};
  localparam logic [ML_W-1:0] MlMax = {ML_W{1'b1}};

  burst_state_e     state_q, state_d;
  logic [RAW_W-1:0] raw_q, raw_d;
  logic [CM_W-1:0]  cm_q, cm_d, dist_q, dist_d;
  logic [SumW-1:0]  sum_q, sum_d, sum_next;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [ML_W-1:0]  vol_q, vol_d, vol_sat, vol_calc;
  logic             valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic             ping_start, tmr_done, tmr_timeout;
  logic [RAW_W-1:0] tmr_raw;
  logic [ProdW-1:0] prod, cm_wide;
  logic [CM_W-1:0]  cm_sat, avg, diff;
  logic [VolW-1:0]  vol_full;

  echo_pulse_timer #(
    .RAW_W      (RAW_W),
    .TRIG_CYC   (TRIG_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .ping_start(ping_start),
    .echo      (echo),
    .trig      (trig),
    .raw       (tmr_raw),
    .done      (tmr_done),
    .timeout   (tmr_timeout)
  );

  // Rounded fixed-point scaling: raw counts -> cm
  assign prod    = ProdW'(raw_q) * ProdW'(SCALE_Q[15:0]) + (ProdW'(1) << (SCALE_SH - 1));
  assign cm_wide = prod >> SCALE_SH;
  assign cm_sat  = (cm_wide > ProdW'(CmMax)) ? CmMax : cm_wide[CM_W-1:0];

  assign sum_next = sum_q + SumW'(cm_q);
  assign avg      = CM_W'(sum_next >> AVG_LOG2);
  assign diff     = CM_W'(TANK_H_CM) - avg;
  assign vol_full = VolW'(diff) * VolW'(AREA_CM2);
  assign vol_sat  = (vol_full > VolW'(MlMax)) ? MlMax : vol_full[ML_W-1:0];
  assign vol_calc = (avg >= CM_W'(TANK_H_CM)) ? '0 : vol_sat;

  always_comb begin
    state_d    = state_q;
    raw_d      = raw_q;
    cm_d       = cm_q;
    sum_d      = sum_q;
    pcnt_d     = pcnt_q;
    gap_d      = gap_q;
    dist_d     = dist_q;
    vol_d      = vol_q;
    ping_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StPing;
          ping_start = 1'b1;
          sum_d      = '0;
          pcnt_d     = '0;
        end
      end
      StPing: begin
        if (tmr_timeout) begin
          state_d = StAbort;
          sum_d   = '0;
        end else if (tmr_done) begin
          raw_d   = tmr_raw;
          state_d = StConvert;
        end
      end
      StConvert: begin
        cm_d    = cm_sat;
        state_d = StAccum;
      end
      StAccum: begin
        sum_d = sum_next;
        if (pcnt_q == PcntW'(Pings - 1)) begin
          dist_d  = avg;
          vol_d   = vol_calc;
          state_d = StDone;
        end else begin
          pcnt_d  = pcnt_q + 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYC - 1)) begin
          ping_start = 1'b1;
          state_d    = StPing;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone, StAbort: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
    // Result strobes and busy are registered off the next state so they align with it
    valid_d = (state_d == StDone) || (state_d == StAbort);
    err_d   = (state_d == StAbort);
    busy_d  = !(state_d inside {StIdle, StDone, StAbort});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      raw_q   <= '0;
      cm_q    <= '0;
      sum_q   <= '0;
      pcnt_q  <= '0;
      gap_q   <= '0;
      dist_q  <= '0;
      vol_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      cm_q    <= cm_d;
      sum_q   <= sum_d;
      pcnt_q  <= pcnt_d;
      gap_q   <= gap_d;
      dist_q  <= dist_d;
      vol_q   <= vol_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign dist_cm = dist_q;
  assign vol_ml  = vol_q;
  assign valid   = valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_echo_level_meter.sv
// Directed bench: a single-ping meter and a 4-ping averaging meter, scaled to
// 29 raw counts per cm (SCALE_Q=2260, SCALE_SH=16) with short trigger/gap/timeout.
module tb_echo_level_meter;

  localparam int unsigned TrigCyc    = 5;
  localparam int unsigned TimeoutCyc = 4000;
  localparam int unsigned GapCyc     = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, echo0, trig0, busy0, valid0, err0;
  logic        start2, echo2, trig2, busy2, valid2, err2;
  logic [15:0] dist0, dist2;
  logic [23:0] vol0, vol2;

  int total = 0;
  int bad   = 0;
  int trig2_rises = 0;

  always #5 clk = ~clk;
  always @(posedge trig2) trig2_rises++;

  echo_level_meter #(
    .RAW_W(13), .CM_W(16), .ML_W(24), .TRIG_CYC(TrigCyc), .TIMEOUT_CYC(TimeoutCyc),
    .GAP_CYC(GapCyc), .SCALE_Q(2260), .SCALE_SH(16), .TANK_H_CM(100), .AREA_CM2(400),
    .AVG_LOG2(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .echo(echo0), .trig(trig0), .busy(busy0),
    .dist_cm(dist0), .vol_ml(vol0), .valid(valid0), .err(err0)
  );

  echo_level_meter #(
    .RAW_W(13), .CM_W(16), .ML_W(24), .TRIG_CYC(TrigCyc), .TIMEOUT_CYC(TimeoutCyc),
    .GAP_CYC(GapCyc), .SCALE_Q(2260), .SCALE_SH(16), .TANK_H_CM(100), .AREA_CM2(400),
    .AVG_LOG2(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .echo(echo2), .trig(trig2), .busy(busy2),
    .dist_cm(dist2), .vol_ml(vol2), .valid(valid2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_trig(input bit sel, output bit ok);
    bit hi = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((sel ? trig2 : trig0) === 1'b1) begin hi = 1'b1; break; end
    end
    if (hi) begin
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if ((sel ? trig2 : trig0) === 1'b0) begin ok = 1'b1; break; end
      end
    end
  endtask

  task automatic drive_echo(input bit sel, input int width);
    repeat (10) @(negedge clk);
    if (sel) echo2 = 1'b1; else echo0 = 1'b1;
    repeat (width) @(negedge clk);
    if (sel) echo2 = 1'b0; else echo0 = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((sel ? valid2 : valid0) === 1'b1) begin seen = 1'b1; break; end
    end
  endtask

  task automatic run_single(input string tag, input int width, input int d, input int v);
    bit ok;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    chk({tag, "_busy_set"}, busy0, 1);
    wait_trig(1'b0, ok);
    chk({tag, "_trig"}, ok, 1);
    drive_echo(1'b0, width);
    wait_valid(1'b0, 200, ok);
    chk({tag, "_valid_seen"}, ok, 1);
    chk({tag, "_dist"}, dist0, d);
    chk({tag, "_vol"}, vol0, v);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_busy_clr"}, busy0, 0);
    @(negedge clk);
    chk({tag, "_valid_1clk"}, valid0, 0);
  endtask

  initial begin
    bit ok;
    int w2 [4] = '{580, 580, 609, 609};
    rst_n = 1'b0;
    start0 = 1'b0; echo0 = 1'b0; start2 = 1'b0; echo2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dist0", dist0, 0);
    chk("rst_vol0", vol0, 0);
    chk("rst_flags0", {trig0, busy0, valid0, err0}, 0);
    chk("rst_flags2", {trig2, busy2, valid2, err2}, 0);
    rst_n = 1'b1;

    // Single ping: 2900 -> 100 cm, 1450 -> 50 cm, 580 -> 20 cm
    run_single("t1", 2900, 100, 0);
    run_single("t2a", 1450, 50, 20000);
    run_single("t2b", 580, 20, 32000);

    // Four-ping average: 20,20,21,21 cm -> 82 >> 2 = 20
    trig2_rises = 0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_trig(1'b1, ok);
      chk("t3_trig", ok, 1);
      drive_echo(1'b1, w2[k]);
    end
    wait_valid(1'b1, 200, ok);
    chk("t3_valid_seen", ok, 1);
    chk("t3_dist", dist2, 20);
    chk("t3_vol", vol2, 32000);
    chk("t3_err", err2, 0);
    chk("t3_busy", busy2, 0);
    chk("t3_trig_count", trig2_rises, 4);

    // No echo: wait-rise timeout, previous result held
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait_valid(1'b0, TimeoutCyc + 200, ok);
    chk("t4_valid_seen", ok, 1);
    chk("t4_err", err0, 1);
    chk("t4_dist_held", dist0, 20);
    chk("t4_vol_held", vol0, 32000);
    chk("t4_busy", busy0, 0);

    // Echo stuck high; starts while busy must be dropped
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait_trig(1'b0, ok);
    chk("t5_trig", ok, 1);
    repeat (10) @(negedge clk);
    echo0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < TimeoutCyc + 200; i++) begin
      @(negedge clk);
      if (valid0 === 1'b1) begin ok = 1'b1; break; end
      start0 = (i % 500 == 100) && (i < 3500);
    end
    start0 = 1'b0;
    chk("t5_valid_seen", ok, 1);
    chk("t5_err", err0, 1);
    chk("t5_dist_held", dist0, 20);
    echo0 = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_no_rerun", {busy0, trig0}, 0);

    // Reset mid-measure, then a clean burst
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait_trig(1'b0, ok);
    repeat (10) @(negedge clk);
    echo0 = 1'b1;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", {trig0, busy0, valid0}, 0);
    chk("t6_rst_dist", dist0, 0);
    echo0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_single("t6", 1450, 50, 20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
